inst_fetch_queue: RTL and testbench

//  Prefetch stage that sits upstream of the CPU decode/execute datapath and keeps it fed from a

---
 rtl/inst_fetch_queue_if.sv | 43 ++++
 rtl/inst_fetch_queue.sv | 107 ++++++++++
 tb/tb_inst_fetch_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch queue bus: imem request/response, instruction output, redirect/halt
//
// Purpose: groups every non-clock/reset signal of inst_fetch_queue.
//   master : the fetch queue itself (drives imem requests, instruction head, occupancy)
//   slave  : its environment (instruction memory plus the CPU datapath)
// Signals:
//   imem_req_valid/imem_req_addr/imem_req_ready : sequential fetch requests
//   imem_resp_valid/imem_resp_data              : in-order instruction words
//   inst_valid/inst_out/inst_pc/inst_ready      : queue head handshake
//   redirect/redirect_pc                        : control-flow change
//   halt                                        : level, suppresses new requests
//   occupancy                                   : valid entries in the queue
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             imem_req_valid;
    logic [31:0]      imem_req_addr;
    logic             imem_req_ready;
    logic             imem_resp_valid;
    logic [31:0]      imem_resp_data;
    logic             inst_valid;
    logic [31:0]      inst_out;
    logic [31:0]      inst_pc;
    logic             inst_ready;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             halt;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc, occupancy,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc, occupancy,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect, redirect_pc, halt
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction prefetch queue with redirect flush and in-flight drop
//
// Purpose: issues sequential word-aligned fetches, buffers in-order responses as {pc, inst}
// in a DEPTH-entry registered FIFO and presents the head with a valid/ready handshake.
// A redirect flushes the queue and marks every still-outstanding response for discard.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-low
//   bus   : inst_fetch_queue_if.master (imem request/response, queue head, redirect, halt,
//           occupancy)
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic                clk,
    input logic                reset,
    inst_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetchPc;
    logic [31:0]      respPc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] dropCnt;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [31:0]      pcMem   [DEPTH];
    logic [31:0]      instMem [DEPTH];

    logic             reqFire;
    logic             respAccept;
    logic             respKeep;
    logic             popFire;
    logic [CNT_W:0]   slotsUsed;
    logic [CNT_W-1:0] outstandingNext;
    logic [31:0]      redirectAligned;

    // Every queue slot is reserved from request time, so a response can never find the
    // FIFO full. A pop in this cycle is deliberately not credited.
    assign slotsUsed          = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = reset && !bus.halt && (slotsUsed < DEPTH_SUM);
    assign bus.imem_req_addr  = fetchPc;

    assign reqFire    = bus.imem_req_valid && bus.imem_req_ready;
    assign respAccept = bus.imem_resp_valid && (outstanding != '0);
    // A response arriving with a redirect belongs to the old path and is discarded.
    assign respKeep   = respAccept && (dropCnt == '0) && !bus.redirect;
    assign popFire    = bus.inst_valid && bus.inst_ready;

    assign outstandingNext = outstanding + CNT_W'(reqFire) - CNT_W'(respAccept);
    assign redirectAligned = bus.redirect_pc & 32'hFFFF_FFFC;

    // Head outputs are forced to zero when empty so they read as zero throughout reset.
    assign bus.inst_valid = (count != '0);
    assign bus.inst_out   = bus.inst_valid ? instMem[headPtr] : 32'h0;
    assign bus.inst_pc    = bus.inst_valid ? pcMem[headPtr]   : 32'h0;
    assign bus.occupancy  = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
            headPtr     <= '0;
            tailPtr     <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (bus.redirect) begin
                // Everything still outstanding after this cycle is on the old path,
                // including a request handshaked right now.
                fetchPc <= redirectAligned;
                respPc  <= redirectAligned;
                count   <= '0;
                headPtr <= '0;
                tailPtr <= '0;
                dropCnt <= outstandingNext;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + 32'd4;
                end
                if (respAccept && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - 1'b1;
                end
                if (respKeep) begin
                    tailPtr <= tailPtr + 1'b1;
                    respPc  <= respPc + 32'd4;
                end
                if (popFire) begin
                    headPtr <= headPtr + 1'b1;
                end
                count <= count + CNT_W'(respKeep) - CNT_W'(popFire);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (respKeep) begin
            pcMem[tailPtr]   <= respPc;
            instMem[tailPtr] <= bus.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        int          epoch;
        logic [31:0] addr;
    } FlightEntry;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } QueueEntry;

    logic clk;
    logic reset;

    inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;
    int popCount = 0;
    int dropCount = 0;

    FlightEntry  inflight[$];
    QueueEntry   sbQ[$];
    logic [31:0] memQ[$];
    logic [31:0] expFetch = RESET_PC;
    int          epoch = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: runs after the monitor in each cycle, applies the cycle's handshakes.
    // Requests issued before a redirect carry an older epoch and are dropped on return.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            inflight.delete();
            sbQ.delete();
            memQ.delete();
            expFetch = RESET_PC;
            epoch    = 0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", bus.imem_req_addr, expFetch);
                inflight.push_back('{epoch, bus.imem_req_addr});
                memQ.push_back(bus.imem_req_addr);
                expFetch = expFetch + 32'd4;
            end
            if (bus.imem_resp_valid) begin
                if (inflight.size() == 0) begin
                    check("resp_without_request", 32'd1, 32'd0);
                end else begin
                    FlightEntry f;
                    f = inflight.pop_front();
                    if (f.epoch == epoch && !bus.redirect)
                        sbQ.push_back('{f.addr, memData(f.addr)});
                    else
                        dropCount++;
                end
            end
            if (bus.redirect) begin
                epoch++;
                expFetch = bus.redirect_pc & 32'hFFFF_FFFC;
                sbQ.delete();
            end
        end
    end

    // Monitor: compares the presented head and bookkeeping against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            logic expReqValid;
            check("occupancy", 32'(bus.occupancy), 32'(sbQ.size()));
            expReqValid = !bus.halt && ((sbQ.size() + inflight.size()) < DEPTH);
            check("req_valid", 32'(bus.imem_req_valid), 32'(expReqValid));
            if (bus.inst_valid) begin
                if (sbQ.size() == 0) begin
                    check("unexpected_head_pc", bus.inst_pc, 32'hxxxx_xxxx);
                end else begin
                    check("head_pc", bus.inst_pc, sbQ[0].pc);
                    check("head_inst", bus.inst_out, sbQ[0].inst);
                    if (bus.inst_ready) begin
                        void'(sbQ.pop_front());
                        popCount++;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] pickRedirectPc();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0103;
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom & 32'h0000_FFFF;
        endcase
    endfunction

    task automatic runPhase(input int cycles, input int reqPct, input int respPct,
                            input int readyPct, input int redirPct, input int haltPct);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            bus.imem_req_ready = ($urandom_range(0, 99) < reqPct);
            bus.inst_ready     = ($urandom_range(0, 99) < readyPct);
            bus.halt           = ($urandom_range(0, 99) < haltPct);
            bus.redirect       = ($urandom_range(0, 99) < redirPct);
            bus.redirect_pc    = pickRedirectPc();
            if (memQ.size() > 0 && $urandom_range(0, 99) < respPct) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = memData(memQ.pop_front());
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = $urandom;
            end
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_req_valid"},  32'(bus.imem_req_valid), 32'd0);
        check({tag, "_inst_valid"}, 32'(bus.inst_valid),     32'd0);
        check({tag, "_inst_out"},   bus.inst_out,            32'd0);
        check({tag, "_inst_pc"},    bus.inst_pc,             32'd0);
        check({tag, "_occupancy"},  32'(bus.occupancy),      32'd0);
    endtask

    initial begin
        reset               = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.inst_ready      = 1'b1;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.halt            = 1'b0;
        #1;
        checkReset("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        runPhase(40, 100, 100, 100, 0, 0);
        runPhase(20, 100, 100, 0, 0, 0);
        runPhase(20, 100, 100, 100, 0, 0);
        runPhase(1500, 70, 50, 60, 5, 10);
        runPhase(500, 100, 30, 80, 2, 40);

        @(posedge clk);
        #3;
        reset               = 1'b0;
        bus.halt            = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.redirect        = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.inst_ready      = 1'b1;
        #1 checkReset("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        runPhase(30, 100, 100, 100, 0, 0);
        runPhase(1000, 50, 70, 50, 8, 5);

        @(posedge clk);
        #1;
        bus.redirect        = 1'b0;
        bus.imem_resp_valid = 1'b0;
        check("pops_seen", 32'(popCount > 300), 32'd1);
        check("drops_seen", 32'(dropCount > 10), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
